// File: rtl/tty_uart_tx_pkg.sv
// rtl/tty_uart_tx_pkg.sv - shared definitions for the TTY UART transmitter
//
// Purpose: state encodings, frame constants and the baud divisor helper that
//          are shared by the TTY write path.
// Contents: tty_tx_state_t, TTY_FRAME_BITS, TTY_LOCATION_DEFAULT, tty_divisor().
package tty_uart_tx_pkg;

   typedef enum logic [1:0] {
      TTY_TX_IDLE  = 2'd0,
      TTY_TX_START = 2'd1,
      TTY_TX_DATA  = 2'd2,
      TTY_TX_STOP  = 2'd3
   } tty_tx_state_t;

   // Start bit + 8 data bits + stop bit.
   localparam int TTY_FRAME_BITS = 10;

   // Memory-mapped address of the TTY write port. The CPU memory interface and
   // this block both pick it up from here so they cannot drift apart.
   localparam logic [31:0] TTY_LOCATION_DEFAULT = 32'hFFFF_FFF0;

   // Nearest-integer clock cycles per serial bit.
   function automatic int tty_divisor(input int clock_frequency, input int baud_rate);
      return (clock_frequency + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/tty_fifo.sv
// rtl/tty_fifo.sv - byte FIFO between the TTY write strobe and the serialiser
//
// Purpose: circular buffer of 2**depth_log2 bytes with a registered full flag.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   push, push_data     write strobe and byte; ignored while full=1
//   pop, pop_data       read strobe; pop_data shows the head byte combinationally
//   empty               1 when no bytes are held
//   full                registered, 1 when all entries are occupied
module tty_fifo #(
   parameter int depth_log2 = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       empty,
   output logic       full
);

   localparam int depth = 1 << depth_log2;
   localparam logic [depth_log2:0] depth_count = (depth_log2 + 1)'(depth);

   logic [7:0]            mem [depth];
   logic [depth_log2-1:0] wr_ptr;
   logic [depth_log2-1:0] rd_ptr;
   logic [depth_log2:0]   count;
   logic [depth_log2:0]   count_next;
   logic                  push_ok;
   logic                  pop_ok;

   // full is the registered flag from the start of the cycle, so a push in
   // the same cycle as a pop is only taken when the FIFO was not full.
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok) begin
         count_next = count + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
         full  <= (count_next == depth_count);
      end
   end

   // Storage needs no reset; count guards every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/tty_uart_tx.sv
// rtl/tty_uart_tx.sv - TTY write port consumer and 8N1 UART transmitter
//
// Purpose: queues bytes written by the CPU memory interface and sends them as
//          8N1 frames, back to back while bytes remain queued.
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   tty_write       one-cycle byte write strobe
//   tty_write_data  byte to send, valid with tty_write
//   tty_write_busy  registered, 1 while the FIFO is full (writes dropped)
//   tx              registered UART serial output, idle high
module tty_uart_tx
   import tty_uart_tx_pkg::*;
#(
   parameter int clock_frequency = 12000000,
   parameter int baud_rate       = 115200,
   parameter int fifo_depth_log2 = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tty_write,
   input  logic [7:0] tty_write_data,
   output logic       tty_write_busy,
   output logic       tx
);

   localparam int divisor = tty_divisor(clock_frequency, baud_rate);
   localparam int baud_w  = $clog2(divisor);
   localparam logic [baud_w-1:0] baud_last = baud_w'(divisor - 1);

   if (divisor < 2) begin : g_bad_divisor
      $error("tty_uart_tx: divisor must be at least 2");
   end
   if (fifo_depth_log2 < 1 || fifo_depth_log2 > 6) begin : g_bad_depth
      $error("tty_uart_tx: fifo_depth_log2 must be in 1..6");
   end

   tty_tx_state_t     state_q, state_d;
   logic [baud_w-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              fifo_pop;
   logic [7:0]        fifo_data;
   logic              fifo_empty;
   logic              fifo_full;
   logic              baud_end;

   tty_fifo #(
      .depth_log2 (fifo_depth_log2)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tty_write),
      .push_data (tty_write_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign tty_write_busy = fifo_full;
   assign tx             = tx_q;
   assign baud_end       = (baud_q == baud_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TTY_TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // tx_d is the line level for the state being left at this edge, so tx
   // trails the state by exactly one cycle in every state and frames stay
   // exactly TTY_FRAME_BITS * divisor cycles long.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
      fifo_pop = 1'b0;
      case (state_q)
         TTY_TX_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_data;
               baud_d   = '0;
               state_d  = TTY_TX_START;
            end
         end
         TTY_TX_START: begin
            tx_d = 1'b0;
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = TTY_TX_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         TTY_TX_DATA: begin
            tx_d = shift_q[0];
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = TTY_TX_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         TTY_TX_STOP: begin
            tx_d = 1'b1;
            if (baud_end) begin
               baud_d = '0;
               // Chain straight into the next start bit when more is queued.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_data;
                  state_d  = TTY_TX_START;
               end else begin
                  state_d = TTY_TX_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = TTY_TX_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tty_uart_tx.sv
// tb/tb_tty_uart_tx.sv - scoreboard testbench for tty_uart_tx
module tb_tty_uart_tx;

   localparam int DIV   = 10;
   localparam int FRAME = 10 * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tty_write = 1'b0;
   logic [7:0] tty_write_data = 8'h00;
   logic       tty_write_busy;
   logic       tx;

   int         assertions = 0;
   int         failures = 0;
   int         cyc = 0;

   logic [7:0] exp_q[$];
   int         frame_starts[$];

   bit         mon_active = 1'b0;
   int         mon_cnt = 0;
   int         bitn;
   logic [7:0] mon_shift;
   logic [7:0] exp_byte;

   tty_uart_tx #(
      .clock_frequency (1000000),
      .baud_rate       (100000),
      .fifo_depth_log2 (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tty_write      (tty_write),
      .tty_write_data (tty_write_data),
      .tty_write_busy (tty_write_busy),
      .tx             (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // UART receiver: samples each bit at its middle and pops the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt = 0;
            frame_starts.push_back(cyc);
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % DIV == DIV / 2) begin
            bitn = mon_cnt / DIV;
            if (bitn == 0) begin
               check("start_bit", {31'd0, tx}, 32'd0);
            end else if (bitn <= 8) begin
               mon_shift[bitn-1] = tx;
            end else begin
               check("stop_bit", {31'd0, tx}, 32'd1);
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", {24'd0, mon_shift}, 32'hFFFF_FFFF);
               end else begin
                  exp_byte = exp_q.pop_front();
                  check("frame_data", {24'd0, mon_shift}, {24'd0, exp_byte});
               end
               mon_active = 1'b0;
            end
         end
      end
   end

   // Called at a negedge; the write is sampled at the following posedge.
   task automatic write_byte(input logic [7:0] b, input bit accepted);
      tty_write = 1'b1;
      tty_write_data = b;
      if (accepted) exp_q.push_back(b);
      @(negedge clk);
      tty_write = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || mon_active) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, (exp_q.size() == 0 && !mon_active)}, 32'd1);
      repeat (20) @(negedge clk);
   endtask

   task automatic check_contiguous(input string name, input int nframes);
      check({name, "_count"}, frame_starts.size(), nframes);
      for (int i = 1; i < frame_starts.size(); i++) begin
         check({name, "_gap"}, frame_starts[i] - frame_starts[i-1], FRAME);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;

      // Reset and idle.
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, tty_write_busy}, 32'd0);
      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || tty_write_busy !== 1'b0) bad++;
      end
      check("idle_100_cycles_bad", bad, 0);

      // Single byte and its start latency.
      write_byte(8'h55, 1'b1);
      check("latency_e1_tx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      check("latency_e1b_tx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      check("latency_e2_tx", {31'd0, tx}, 32'd0);
      drain("drain_single");

      // Burst of five into a depth-4 FIFO, plus a dropped write while full.
      frame_starts.delete();
      for (int i = 0; i < 5; i++) begin
         write_byte(8'h41 + 8'(i), 1'b1);
         check("burst_busy", {31'd0, tty_write_busy}, (i == 4) ? 32'd1 : 32'd0);
      end
      write_byte(8'hFF, 1'b0);
      repeat (95) @(negedge clk);
      check("busy_before_pop2", {31'd0, tty_write_busy}, 32'd1);
      @(negedge clk);
      check("busy_after_pop2", {31'd0, tty_write_busy}, 32'd0);
      drain("drain_burst");
      check_contiguous("burst", 5);

      // Reset in the middle of a frame with two bytes queued.
      write_byte(8'h31, 1'b1);
      write_byte(8'h32, 1'b1);
      write_byte(8'h33, 1'b1);
      repeat (32) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midreset_tx", {31'd0, tx}, 32'd1);
      check("midreset_busy", {31'd0, tty_write_busy}, 32'd0);
      reset = 1'b0;
      frame_starts.delete();
      bad = 0;
      repeat (250) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      check("after_reset_quiet_bad", bad, 0);
      check("after_reset_no_frames", frame_starts.size(), 0);
      write_byte(8'h0D, 1'b1);
      drain("drain_after_reset");

      // Push landing on the same edge as the STOP-end pop with count=1.
      frame_starts.delete();
      write_byte(8'hA0, 1'b1);
      write_byte(8'hA1, 1'b1);
      repeat (99) @(negedge clk);
      write_byte(8'hA2, 1'b1);
      check("stoppush_busy0", {31'd0, tty_write_busy}, 32'd0);
      write_byte(8'hA3, 1'b1);
      check("stoppush_busy1", {31'd0, tty_write_busy}, 32'd0);
      write_byte(8'hA4, 1'b1);
      check("stoppush_busy2", {31'd0, tty_write_busy}, 32'd0);
      write_byte(8'hA5, 1'b1);
      check("stoppush_busy3", {31'd0, tty_write_busy}, 32'd1);
      drain("drain_stoppush");
      check_contiguous("stoppush", 6);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
